// File: rtl/pacman_ctrl_pkg.sv
// Shared types for the Pac-Man movement engine: directions, maze tile codes,
// controller states, and small helpers used by the controller.
package pacman_pkg;

   typedef enum logic [1:0] {
      RIGHT = 2'd0,
      LEFT  = 2'd1,
      UP    = 2'd2,
      DOWN  = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      PELLET = 2'd1,
      POWER  = 2'd2,
      WALL   = 2'd3
   } tile_t;

   typedef enum logic [1:0] {
      READY = 2'd0,
      MOVE  = 2'd1,
      DYING = 2'd2,
      DEAD  = 2'd3
   } state_t;

   function automatic dir_t opposite_dir(input dir_t d);
      dir_t r;
      case (d)
         RIGHT:   r = LEFT;
         LEFT:    r = RIGHT;
         UP:      r = DOWN;
         default: r = UP;
      endcase
      return r;
   endfunction

   // Neighbour code in direction d; tile_info packs one 2-bit code per direction.
   function automatic tile_t tile_at(input logic [7:0] info, input dir_t d);
      logic [7:0] sh;
      sh = info >> (2 * int'(d));
      return tile_t'(sh[1:0]);
   endfunction

endpackage

// File: rtl/pacman_ctrl_if.sv
// Game-side bundle between the maze/input logic and the movement engine.
// master = game side (drives tick/requests/maze info), slave = pacman_ctrl.
interface pacman_ctrl_if #(
   parameter int TILE_W = 7,
   parameter int LOC_W  = 10
);
   import pacman_pkg::*;

   logic              tick;
   logic              dir_req_valid;
   dir_t              dir_req;
   logic [7:0]        tile_info;
   logic              kill;
   logic              respawn;
   logic [TILE_W-1:0] xtile;
   logic [TILE_W-1:0] ytile;
   logic [LOC_W-1:0]  xloc;
   logic [LOC_W-1:0]  yloc;
   dir_t              dir;
   logic [1:0]        animation;
   logic              moving;
   logic              alive;

   modport master (
      output tick, dir_req_valid, dir_req, tile_info, kill, respawn,
      input  xtile, ytile, xloc, yloc, dir, animation, moving, alive
   );

   modport slave (
      input  tick, dir_req_valid, dir_req, tile_info, kill, respawn,
      output xtile, ytile, xloc, yloc, dir, animation, moving, alive
   );

endinterface

// File: rtl/pacman_step_gen.sv
// Game-tick divider: one step pulse every STEP_DIV ticks while enabled.
// The count is held at zero while disabled so every enable starts a fresh period.
module pacman_step_gen #(
   parameter int STEP_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   input  logic tick_i,
   output logic step_o
);

   localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   // Count ticks, wrap at the terminal count and fire the step in that cycle.
   always_comb begin
      cnt_d  = cnt_q;
      step_o = 1'b0;
      if (!en_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            step_o = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/pacman_ctrl.sv
// Pac-Man player movement engine: buffered turns, wall stops, tunnel wrap and
// the death/respawn sequence. Optional macro PACMAN_PELLET_SLOW_EN pauses one
// step after entering a pellet or power-pellet tile.
//
// state | meaning
// READY | parked at spawn, waiting for the first direction request
// MOVE  | advancing one sub-tile pixel per step
// DYING | death animation, one frame every ANIM_DIV ticks
// DEAD  | frozen until respawn
module pacman_ctrl #(
   parameter int TILE_SHIFT  = 3,
   parameter int CENTER_PX   = 3,
   parameter int TILE_W      = 7,
   parameter int LOC_W       = 10,
   parameter int MAZE_W      = 28,
   parameter int Y_TILE_OFS  = 3,
   parameter int START_XTILE = 14,
   parameter int START_YTILE = 26,
   parameter int STEP_DIV    = 1,
   parameter int ANIM_DIV    = 2
) (
   input logic          clk,
   input logic          rst,
   pacman_ctrl_if.slave bus
);
   import pacman_pkg::*;

   localparam int                SUB_W     = TILE_SHIFT;
   localparam logic [SUB_W-1:0]  SUB_ONE   = SUB_W'(1);
   localparam logic [SUB_W-1:0]  SUB_MAX   = {SUB_W{1'b1}};
   localparam logic [SUB_W-1:0]  CTR_PX    = SUB_W'(CENTER_PX);
   localparam logic [TILE_W-1:0] TILE_ONE  = TILE_W'(1);
   localparam logic [TILE_W-1:0] MAZE_LAST = TILE_W'(MAZE_W - 1);
   localparam logic [TILE_W-1:0] START_X   = TILE_W'(START_XTILE);
   localparam logic [TILE_W-1:0] START_Y   = TILE_W'(START_YTILE);
   localparam logic [7:0]        ANIM_LAST = 8'(ANIM_DIV - 1);

   state_t            state_q, state_d;
   logic [TILE_W-1:0] xtile_q, xtile_d, ytile_q, ytile_d;
   logic [SUB_W-1:0]  xsub_q, xsub_d, ysub_q, ysub_d;
   dir_t              dir_q, dir_d;
   logic [1:0]        anim_q, anim_d;
   logic [7:0]        anim_cnt_q, anim_cnt_d;
   logic              moving_q, moving_d;
   logic              buf_vld_q, buf_vld_d;
   dir_t              buf_dir_q, buf_dir_d;
`ifdef PACMAN_PELLET_SLOW_EN
   logic              slow_q, slow_d;
`else
   logic              slow_q;
   assign slow_q = 1'b0;
`endif

   logic step;
   logic req_vld, at_ctr, adv, take, dies;
   dir_t req_dir, adv_dir;

   pacman_step_gen #(.STEP_DIV(STEP_DIV)) u_step_gen (
      .clk    (clk),
      .rst    (rst),
      .en_i   (state_q == MOVE),
      .tick_i (bus.tick),
      .step_o (step)
   );

   assign dies = bus.kill && (state_q == READY || state_q == MOVE);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= READY;
      else      state_q <= state_d;
   end

   // Next-state logic; kill outranks every other event in READY/MOVE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         READY: if (bus.kill) state_d = DYING;
                else if (bus.dir_req_valid) state_d = MOVE;
         MOVE:  if (bus.kill) state_d = DYING;
         DYING: if (bus.tick && anim_cnt_q == ANIM_LAST && anim_q == 2'd3) state_d = DEAD;
         DEAD:  if (bus.respawn) state_d = READY;
         default: state_d = READY;
      endcase
   end

   // Movement datapath: request buffer, turn/stop decision, advance and animation.
   always_comb begin
      xtile_d    = xtile_q;
      ytile_d    = ytile_q;
      xsub_d     = xsub_q;
      ysub_d     = ysub_q;
      dir_d      = dir_q;
      anim_d     = anim_q;
      anim_cnt_d = anim_cnt_q;
      moving_d   = moving_q;
      buf_vld_d  = buf_vld_q;
      buf_dir_d  = buf_dir_q;
`ifdef PACMAN_PELLET_SLOW_EN
      slow_d     = slow_q;
`endif
      req_vld = bus.dir_req_valid | buf_vld_q;
      req_dir = bus.dir_req_valid ? bus.dir_req : buf_dir_q;
      at_ctr  = (xsub_q == CTR_PX) && (ysub_q == CTR_PX);
      adv     = 1'b0;
      adv_dir = dir_q;
      take    = 1'b0;

      if (dies) begin
         anim_d     = 2'd0;
         anim_cnt_d = '0;
         moving_d   = 1'b0;
         buf_vld_d  = 1'b0;
`ifdef PACMAN_PELLET_SLOW_EN
         slow_d     = 1'b0;
`endif
      end else begin
         unique case (state_q)
            READY: if (bus.dir_req_valid) dir_d = bus.dir_req;
            MOVE: begin
               if (bus.dir_req_valid) begin
                  buf_vld_d = 1'b1;
                  buf_dir_d = bus.dir_req;
               end
               if (step && slow_q) begin
`ifdef PACMAN_PELLET_SLOW_EN
                  slow_d = 1'b0;
`endif
               end else if (step) begin
                  // Reversal is always legal; other turns only at the tile centre.
                  if (req_vld && req_dir == opposite_dir(dir_q)) begin
                     adv = 1'b1; adv_dir = req_dir; take = 1'b1;
                  end else if (!at_ctr) begin
                     adv = 1'b1;
                  end else if (req_vld && tile_at(bus.tile_info, req_dir) != WALL) begin
                     adv = 1'b1; adv_dir = req_dir; take = 1'b1;
                  end else if (tile_at(bus.tile_info, dir_q) != WALL) begin
                     adv = 1'b1;
                  end
                  moving_d = adv;
               end
               if (take) buf_vld_d = 1'b0;
               if (adv) begin
                  dir_d = adv_dir;
                  unique case (adv_dir)
                     RIGHT: begin
                        xsub_d = xsub_q + SUB_ONE;
                        if (xsub_q == SUB_MAX)
                           xtile_d = (xtile_q == MAZE_LAST) ? '0 : xtile_q + TILE_ONE;
                     end
                     LEFT: begin
                        xsub_d = xsub_q - SUB_ONE;
                        if (xsub_q == '0)
                           xtile_d = (xtile_q == '0) ? MAZE_LAST : xtile_q - TILE_ONE;
                     end
                     UP: begin
                        ysub_d = ysub_q - SUB_ONE;
                        if (ysub_q == '0) ytile_d = ytile_q - TILE_ONE;
                     end
                     default: begin
                        ysub_d = ysub_q + SUB_ONE;
                        if (ysub_q == SUB_MAX) ytile_d = ytile_q + TILE_ONE;
                     end
                  endcase
                  if (anim_cnt_q == ANIM_LAST) begin
                     anim_cnt_d = '0;
                     anim_d     = anim_q + 2'd1;
                  end else begin
                     anim_cnt_d = anim_cnt_q + 8'd1;
                  end
`ifdef PACMAN_PELLET_SLOW_EN
                  slow_d = ((xtile_d != xtile_q) || (ytile_d != ytile_q)) &&
                           (tile_at(bus.tile_info, adv_dir) == PELLET ||
                            tile_at(bus.tile_info, adv_dir) == POWER);
`endif
               end
            end
            DYING: begin
               if (bus.tick) begin
                  if (anim_cnt_q == ANIM_LAST) begin
                     anim_cnt_d = '0;
                     if (anim_q != 2'd3) anim_d = anim_q + 2'd1;
                  end else begin
                     anim_cnt_d = anim_cnt_q + 8'd1;
                  end
               end
            end
            DEAD: begin
               if (bus.respawn) begin
                  xtile_d    = START_X;
                  ytile_d    = START_Y;
                  xsub_d     = CTR_PX;
                  ysub_d     = CTR_PX;
                  dir_d      = LEFT;
                  anim_d     = 2'd0;
                  anim_cnt_d = '0;
                  moving_d   = 1'b0;
                  buf_vld_d  = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         xtile_q    <= START_X;
         ytile_q    <= START_Y;
         xsub_q     <= CTR_PX;
         ysub_q     <= CTR_PX;
         dir_q      <= LEFT;
         anim_q     <= 2'd0;
         anim_cnt_q <= '0;
         moving_q   <= 1'b0;
         buf_vld_q  <= 1'b0;
         buf_dir_q  <= LEFT;
`ifdef PACMAN_PELLET_SLOW_EN
         slow_q     <= 1'b0;
`endif
      end else begin
         xtile_q    <= xtile_d;
         ytile_q    <= ytile_d;
         xsub_q     <= xsub_d;
         ysub_q     <= ysub_d;
         dir_q      <= dir_d;
         anim_q     <= anim_d;
         anim_cnt_q <= anim_cnt_d;
         moving_q   <= moving_d;
         buf_vld_q  <= buf_vld_d;
         buf_dir_q  <= buf_dir_d;
`ifdef PACMAN_PELLET_SLOW_EN
         slow_q     <= slow_d;
`endif
      end
   end

   // Outputs: tile/pixel location and status derived from the registers.
   always_comb begin
      bus.xtile     = xtile_q;
      bus.ytile     = ytile_q;
      bus.xloc      = (LOC_W'(xtile_q) << TILE_SHIFT) + LOC_W'(xsub_q);
      bus.yloc      = ((LOC_W'(ytile_q) + LOC_W'(Y_TILE_OFS)) << TILE_SHIFT) + LOC_W'(ysub_q);
      bus.dir       = dir_q;
      bus.animation = anim_q;
      bus.moving    = moving_q;
      bus.alive     = (state_q == READY) || (state_q == MOVE);
   end

endmodule

// File: tb/tb_pacman_ctrl.sv
// Bench for pacman_ctrl: directed walk through the main scenarios, then
// random play, all checked every cycle against a pixel-level reference model.
module tb_pacman_ctrl;
   import pacman_pkg::*;

   localparam int TILE_SHIFT = 3;
   localparam int TPX        = 1 << TILE_SHIFT;
   localparam int CENTER_PX  = 3;
   localparam int MAZE_W     = 28;
   localparam int Y_OFS      = 3;
   localparam int START_X    = 14;
   localparam int START_Y    = 26;
   localparam int STEP_DIV   = 1;
   localparam int ANIM_DIV   = 2;
   localparam int MAZE_PX    = MAZE_W * TPX;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pacman_ctrl_if #(.TILE_W(7), .LOC_W(10)) bus ();

   pacman_ctrl #(
      .TILE_SHIFT(TILE_SHIFT), .CENTER_PX(CENTER_PX), .TILE_W(7), .LOC_W(10),
      .MAZE_W(MAZE_W), .Y_TILE_OFS(Y_OFS), .START_XTILE(START_X),
      .START_YTILE(START_Y), .STEP_DIV(STEP_DIV), .ANIM_DIV(ANIM_DIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_val(input string tag, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: absolute pixel position, 0=ready 1=move 2=dying 3=dead.
   int m_state, m_px, m_py, m_dir, m_anim, m_anim_cnt, m_moving;
   int m_buf_vld, m_buf_dir, m_step_cnt, m_slow;

   function automatic int tile_of(input int info, input int d);
      return (info >> (2 * d)) & 3;
   endfunction
   function automatic int opp(input int d);
      return (d < 2) ? 1 - d : 5 - d;
   endfunction
   function automatic int dx(input int d);
      return (d == 0) ? 1 : (d == 1) ? -1 : 0;
   endfunction
   function automatic int dy(input int d);
      return (d == 2) ? -1 : (d == 3) ? 1 : 0;
   endfunction

   task automatic model_reset();
      m_state = 0; m_px = START_X * TPX + CENTER_PX; m_py = START_Y * TPX + CENTER_PX;
      m_dir = 1; m_anim = 0; m_anim_cnt = 0; m_moving = 0;
      m_buf_vld = 0; m_buf_dir = 0; m_step_cnt = 0; m_slow = 0;
   endtask

   task automatic model_die();
      m_state = 2; m_anim = 0; m_anim_cnt = 0; m_moving = 0;
      m_buf_vld = 0; m_step_cnt = 0; m_slow = 0;
   endtask

   task automatic model_cycle(input bit tk, input bit v, input int rq, input int info,
                              input bit kl, input bit rs);
      bit step = 0;
      bit rv, taken;
      int rd, nd;
`ifdef PACMAN_PELLET_SLOW_EN
      int otx, oty;
`endif
      if (m_state == 1 && tk) begin
         if (m_step_cnt == STEP_DIV - 1) begin step = 1; m_step_cnt = 0; end
         else m_step_cnt++;
      end
      case (m_state)
         0: if (kl) model_die();
            else if (v) begin m_dir = rq; m_state = 1; end
         1: if (kl) model_die();
            else begin
               rv = v || (m_buf_vld != 0);
               rd = v ? rq : m_buf_dir;
               if (v) begin m_buf_vld = 1; m_buf_dir = rq; end
               if (step && m_slow != 0) m_slow = 0;
               else if (step) begin
                  nd = -1; taken = 0;
                  if (rv && rd == opp(m_dir)) begin nd = rd; taken = 1; end
                  else if (m_px % TPX != CENTER_PX || m_py % TPX != CENTER_PX) nd = m_dir;
                  else if (rv && tile_of(info, rd) != 3) begin nd = rd; taken = 1; end
                  else if (tile_of(info, m_dir) != 3) nd = m_dir;
                  if (nd >= 0) begin
                     if (taken) m_buf_vld = 0;
                     m_dir = nd;
`ifdef PACMAN_PELLET_SLOW_EN
                     otx = m_px / TPX; oty = m_py / TPX;
`endif
                     m_px = (m_px + dx(nd) + MAZE_PX) % MAZE_PX;
                     m_py = m_py + dy(nd);
                     m_anim_cnt++;
                     if (m_anim_cnt == ANIM_DIV) begin m_anim_cnt = 0; m_anim = (m_anim + 1) % 4; end
                     m_moving = 1;
`ifdef PACMAN_PELLET_SLOW_EN
                     if ((m_px / TPX != otx || m_py / TPX != oty) &&
                         (tile_of(info, nd) == 1 || tile_of(info, nd) == 2)) m_slow = 1;
`endif
                  end else begin
                     m_moving = 0;
                  end
               end
            end
         2: if (tk) begin
               m_anim_cnt++;
               if (m_anim_cnt == ANIM_DIV) begin
                  m_anim_cnt = 0;
                  if (m_anim == 3) m_state = 3;
                  else m_anim++;
               end
            end
         default: if (rs) model_reset();
      endcase
   endtask

   task automatic check_all();
      check_val("xtile", int'(bus.xtile), m_px / TPX);
      check_val("ytile", int'(bus.ytile), m_py / TPX);
      check_val("xloc", int'(bus.xloc), m_px);
      check_val("yloc", int'(bus.yloc), (m_py + Y_OFS * TPX) % 1024);
      check_val("dir", int'(bus.dir), m_dir);
      check_val("animation", int'(bus.animation), m_anim);
      check_val("moving", int'(bus.moving), m_moving);
      check_val("alive", int'(bus.alive), (m_state < 2) ? 1 : 0);
   endtask

   task automatic cycle(input bit tk, input bit v, input int rq, input int info,
                        input bit kl, input bit rs);
      bus.tick          = tk;
      bus.dir_req_valid = v;
      bus.dir_req       = dir_t'(rq[1:0]);
      bus.tile_info     = info[7:0];
      bus.kill          = kl;
      bus.respawn       = rs;
      model_cycle(tk, v, rq, info, kl, rs);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      bus.tick = 0; bus.dir_req_valid = 0; bus.dir_req = RIGHT;
      bus.tile_info = 8'h00; bus.kill = 0; bus.respawn = 0;
   endtask

   int info, rq, yt;

   initial begin
      rst = 1'b0;
      idle_inputs();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_xtile", int'(bus.xtile), 14);
      check_val("rst_ytile", int'(bus.ytile), 26);
      check_val("rst_xloc", int'(bus.xloc), 115);
      check_val("rst_yloc", int'(bus.yloc), 235);
      check_val("rst_dir", int'(bus.dir), 1);
      check_val("rst_alive", int'(bus.alive), 1);
      check_val("rst_moving", int'(bus.moving), 0);
      rst = 1'b1;

      // Start right, five steps across the tile boundary.
      cycle(0, 1, 0, 0, 0, 0);
      repeat (5) cycle(1, 0, 0, 0, 0, 0);
      check_val("run_xtile", int'(bus.xtile), 15);
      check_val("run_xloc", int'(bus.xloc), 120);
      check_val("run_anim", int'(bus.animation), 2);

      // Keep going to the right edge and through the tunnel.
      repeat (103) cycle(1, 0, 0, 0, 0, 0);
      check_val("edge_xtile", int'(bus.xtile), 27);
      check_val("edge_xloc", int'(bus.xloc), 223);
      cycle(1, 0, 0, 0, 0, 0);
      check_val("wrap_xtile", int'(bus.xtile), 0);
      check_val("wrap_xloc", int'(bus.xloc), 0);
      repeat (3) cycle(1, 0, 0, 0, 0, 0);
      check_val("ctr_xloc", int'(bus.xloc), 3);

      // Wall to the right at the centre: stop and stay put.
      repeat (10) cycle(1, 0, 0, 8'h03, 0, 0);
      check_val("wall_moving", int'(bus.moving), 0);
      check_val("wall_xloc", int'(bus.xloc), 3);

      // Turn up, perpendicular request off-centre stays buffered, reversal is immediate.
      cycle(0, 1, 2, 8'h03, 0, 0);
      cycle(1, 0, 0, 8'h03, 0, 0);
      check_val("turn_dir", int'(bus.dir), 2);
      check_val("turn_yloc", int'(bus.yloc), 234);
      cycle(0, 1, 1, 8'h03, 0, 0);
      cycle(1, 0, 0, 8'h03, 0, 0);
      check_val("perp_dir", int'(bus.dir), 2);
      check_val("perp_yloc", int'(bus.yloc), 233);
      cycle(0, 1, 3, 8'h03, 0, 0);
      cycle(1, 0, 0, 8'h03, 0, 0);
      check_val("rev_dir", int'(bus.dir), 3);
      check_val("rev_yloc", int'(bus.yloc), 234);

      // Kill together with a step, death animation, respawn.
      cycle(1, 0, 0, 0, 1, 0);
      check_val("kill_alive", int'(bus.alive), 0);
      check_val("kill_anim", int'(bus.animation), 0);
      repeat (4 * ANIM_DIV - 1) cycle(1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 1);
      check_val("early_resp_alive", int'(bus.alive), 0);
      cycle(1, 0, 0, 0, 0, 0);
      check_val("dead_anim", int'(bus.animation), 3);
      cycle(1, 1, 0, 0, 1, 0);
      cycle(0, 0, 0, 0, 0, 1);
      check_val("resp_xtile", int'(bus.xtile), 14);
      check_val("resp_ytile", int'(bus.ytile), 26);
      check_val("resp_alive", int'(bus.alive), 1);
      check_val("resp_dir", int'(bus.dir), 1);

      // Random play; walls fence the vertical range so ytile stays in 2..41.
      for (int i = 0; i < 4000; i++) begin
         yt = m_py / TPX;
         info = 0;
         for (int k = 0; k < 4; k++) info = info | ($urandom_range(0, 3) << (2 * k));
         if (yt <= 2) info = info | (3 << 4);
         if (yt >= 40) info = info | (3 << 6);
         rq = $urandom_range(0, 3);
         if (rq == 2 && yt < 3) rq = 3;
         if (rq == 3 && yt >= 40) rq = 2;
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, rq, info,
               $urandom_range(0, 399) == 0, $urandom_range(0, 15) == 0);
      end

      // Move away from spawn, then reset asynchronously mid-move.
      cycle(0, 1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 1, 0, 0, 0, 0);
      repeat (6) cycle(1, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      check_val("arst_xloc", int'(bus.xloc), 115);
      check_all();
      idle_inputs();
      @(posedge clk);
      #1;
      rst = 1'b1;
      cycle(0, 1, 3, 0, 0, 0);
      repeat (4) cycle(1, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
